// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file.
// Optional feature macro used by the design: REGFILE_BYPASS_EN (write-first read bypass).
package regfile_pkg;

  // Clear sequencer states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W = 32'sd4;
  localparam int DEF_ADDR_W = 32'sd4;

  // Number of entries addressed by an addr_w-bit address
  function automatic int depth_of(input int addr_w);
    return 32'sd1 << addr_w;
  endfunction

endpackage

// File: rtl/param_reg_file_if.sv
// Bus bundle for param_reg_file: one write port, two read ports, clear control and status.
// Optional feature macro used by the design: REGFILE_BYPASS_EN.
interface param_reg_file_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic [ADDR_W-1:0] RdAddrA;
  logic [DATA_W-1:0] RdDataA;
  logic [ADDR_W-1:0] RdAddrB;
  logic [DATA_W-1:0] RdDataB;
  logic              ClrReq;
  logic              Busy;
  logic              ClrDone;
  logic              WrErr;

  modport master (
    output WrEn, WrAddr, WrData, RdAddrA, RdAddrB, ClrReq,
    input  RdDataA, RdDataB, Busy, ClrDone, WrErr
  );

  modport slave (
    input  WrEn, WrAddr, WrData, RdAddrA, RdAddrB, ClrReq,
    output RdDataA, RdDataB, Busy, ClrDone, WrErr
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sweep sequencer: walks a pointer over every entry after a clear request,
// blocks external writes while sweeping and reports Busy / ClrDone / WrErr as registered flags.
// Optional feature macro used by the design: REGFILE_BYPASS_EN (not referenced here).
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic              wr_en,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              wr_accept,
  output logic              busy,
  output logic              clr_done,
  output logic              wr_err
);

  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);

  clr_state_e        state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic              busy_r;
  logic              clr_done_r;
  logic              wr_err_r;

  // State, sweep pointer and status flags; flags describe what the edge just did
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= PTR_ZERO;
      busy_r     <= 1'b0;
      clr_done_r <= 1'b0;
      wr_err_r   <= 1'b0;
    end else begin
      busy_r     <= (state_r == CLEAR);
      clr_done_r <= (state_r == CLEAR) && (ptr_r == PTR_LAST);
      wr_err_r   <= (state_r == CLEAR) && wr_en;
      case (state_r)
        IDLE: begin
          ptr_r <= PTR_ZERO;
          if (clr_req) begin
            state_r <= CLEAR;
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR: begin
          // natural wrap brings the pointer back to zero after the last entry
          ptr_r <= ptr_r + PTR_ONE;
          if (ptr_r == PTR_LAST) begin
            state_r <= IDLE;
          end else begin
            state_r <= CLEAR;
          end
        end
        default: begin
          state_r <= IDLE;
          ptr_r   <= PTR_ZERO;
        end
      endcase
    end
  end

  assign clr_en    = (state_r == CLEAR);
  assign clr_addr  = ptr_r;
  assign wr_accept = wr_en && (state_r == IDLE);
  assign busy      = busy_r;
  assign clr_done  = clr_done_r;
  assign wr_err    = wr_err_r;

endmodule

// File: rtl/param_reg_file.sv
// Parametrised register file: DATA_W x 2^ADDR_W, one write port, two registered read ports,
// hardware clear sweep and write-error flag.
// Optional feature macro: REGFILE_BYPASS_EN selects write-first reads (default read-first).
module param_reg_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic             Clock,
  input  logic             Reset_n,
  param_reg_file_if.slave  bus
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_a_r;
  logic [DATA_W-1:0] rd_b_r;

  logic              clr_en_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              wr_accept_s;
  logic              seq_busy_s;
  logic              seq_done_s;
  logic              seq_err_s;

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_data_s;
  logic              byp_a_s;
  logic              byp_b_s;

  regfile_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .clr_req   (bus.ClrReq),
    .wr_en     (bus.WrEn),
    .clr_en    (clr_en_s),
    .clr_addr  (clr_addr_s),
    .wr_accept (wr_accept_s),
    .busy      (seq_busy_s),
    .clr_done  (seq_done_s),
    .wr_err    (seq_err_s)
  );

  // Write mux: the sweep owns the array while clearing, otherwise an accepted external write
  always_comb begin
    mem_we_s   = 1'b0;
    mem_addr_s = {ADDR_W{1'b0}};
    mem_data_s = DATA_ZERO;
    if (clr_en_s) begin
      mem_we_s   = 1'b1;
      mem_addr_s = clr_addr_s;
      mem_data_s = DATA_ZERO;
    end else if (wr_accept_s) begin
      mem_we_s   = 1'b1;
      mem_addr_s = bus.WrAddr;
      mem_data_s = bus.WrData;
    end else begin
      mem_we_s   = 1'b0;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // only accepted writes forward; dropped writes never reach the read ports
  assign byp_a_s = wr_accept_s && (bus.WrAddr == bus.RdAddrA);
  assign byp_b_s = wr_accept_s && (bus.WrAddr == bus.RdAddrB);
`else
  assign byp_a_s = 1'b0;
  assign byp_b_s = 1'b0;
`endif

  // Storage array; reset zeroes every entry regardless of sweep progress
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 32'sd0; i < DEPTH; i++) begin
        mem_r[i] <= DATA_ZERO;
      end
    end else if (mem_we_s) begin
      mem_r[mem_addr_s] <= mem_data_s;
    end
  end

  // Registered read ports, read-first against the array unless bypass forwards the write
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      rd_a_r <= DATA_ZERO;
      rd_b_r <= DATA_ZERO;
    end else begin
      rd_a_r <= byp_a_s ? bus.WrData : mem_r[bus.RdAddrA];
      rd_b_r <= byp_b_s ? bus.WrData : mem_r[bus.RdAddrB];
    end
  end

  assign bus.RdDataA = rd_a_r;
  assign bus.RdDataB = rd_b_r;
  assign bus.Busy    = seq_busy_s;
  assign bus.ClrDone = seq_done_s;
  assign bus.WrErr   = seq_err_s;

endmodule

// File: tb/tb_param_reg_file.sv
// Self-checking bench for param_reg_file (DATA_W=4, ADDR_W=4) with a behavioural model.
// Honours REGFILE_BYPASS_EN the same way the design does.
module tb_param_reg_file;

  logic clk;
  logic rst_n;

  param_reg_file_if #(.DATA_W(4), .ADDR_W(4)) bus ();

  param_reg_file #(.DATA_W(4), .ADDR_W(4)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model: memory contents, next entry the sweep will clear (-1 = no sweep)
  logic [3:0] mem_m [16];
  int         sweep_k;
  logic [3:0] exp_rda, exp_rdb;
  logic       exp_busy, exp_done, exp_err;
  logic [10:0] got_v, exp_v;

  task automatic idle_inputs();
    bus.WrEn = 1'b0; bus.ClrReq = 1'b0;
  endtask

  // advance one clock, updating the model from the inputs presented for this edge
  task automatic step();
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem_m[i] = 4'h0;
      sweep_k = -1;
      exp_rda = 4'h0; exp_rdb = 4'h0;
      exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    end else begin
      exp_rda = mem_m[bus.RdAddrA];
      exp_rdb = mem_m[bus.RdAddrB];
      if (sweep_k >= 0) begin
        exp_busy = 1'b1;
        exp_err  = bus.WrEn;
        exp_done = (sweep_k == 15);
        mem_m[sweep_k] = 4'h0;
        sweep_k = (sweep_k == 15) ? -1 : sweep_k + 1;
      end else begin
        exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        if (bus.WrEn) begin
          mem_m[bus.WrAddr] = bus.WrData;
`ifdef REGFILE_BYPASS_EN
          if (bus.WrAddr == bus.RdAddrA) exp_rda = bus.WrData;
          if (bus.WrAddr == bus.RdAddrB) exp_rdb = bus.WrData;
`endif
        end
        if (bus.ClrReq) sweep_k = 0;
      end
    end
    @(posedge clk);
    #1;
    got_v = {bus.RdDataA, bus.RdDataB, bus.Busy, bus.ClrDone, bus.WrErr};
    exp_v = {exp_rda, exp_rdb, exp_busy, exp_done, exp_err};
  endtask

  task automatic fill_all(input logic [3:0] val);
    for (int i = 0; i < 16; i++) begin
      bus.WrEn = 1'b1; bus.WrAddr = 4'(i); bus.WrData = val;
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs();
    bus.WrAddr = 4'h0; bus.WrData = 4'h0; bus.RdAddrA = 4'h0; bus.RdAddrB = 4'h0;
    step();
    vectors++;
    if (got_v !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_outputs got {A,B,busy,done,err}=%h required %h", got_v, 11'h000);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.RdAddrA = 4'(i); bus.RdAddrB = 4'(15 - i);
      step();
      vectors++;
      if (got_v !== 11'h000 || got_v !== exp_v) begin
        miscompares++;
        $display("FAIL reset_read i=%0d got %h required %h", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_write_read();
    bus.WrEn = 1'b1; bus.WrAddr = 4'd3; bus.WrData = 4'h5; step();
    bus.WrAddr = 4'd15; bus.WrData = 4'hA; step();
    idle_inputs(); bus.RdAddrA = 4'd3; bus.RdAddrB = 4'd15; step();
    vectors++;
    if (bus.RdDataA !== 4'h5 || bus.RdDataB !== 4'hA || got_v !== exp_v) begin
      miscompares++;
      $display("FAIL write_read got A=%h B=%h required A=5 B=a", bus.RdDataA, bus.RdDataB);
    end
  endtask

  task automatic test_bypass();
    logic [3:0] req;
`ifdef REGFILE_BYPASS_EN
    req = 4'h7;
`else
    req = 4'h0;
`endif
    bus.WrEn = 1'b1; bus.WrAddr = 4'd2; bus.WrData = 4'h7;
    bus.RdAddrA = 4'd2; bus.RdAddrB = 4'd3; step();
    idle_inputs();
    vectors++;
    if (bus.RdDataA !== req || got_v !== exp_v) begin
      miscompares++;
      $display("FAIL same_cycle_read got A=%h required %h (all %h vs %h)", bus.RdDataA, req, got_v, exp_v);
    end
    step();
    vectors++;
    if (bus.RdDataA !== 4'h7) begin
      miscompares++;
      $display("FAIL read_after_write got A=%h required 7", bus.RdDataA);
    end
  endtask

  task automatic test_random_rw();
    for (int i = 0; i < 200; i++) begin
      bus.WrEn = 1'($urandom_range(0, 1)); bus.WrAddr = 4'($urandom_range(0, 15));
      bus.WrData = 4'($urandom_range(0, 15));
      bus.RdAddrA = 4'($urandom_range(0, 15)); bus.RdAddrB = 4'($urandom_range(0, 15));
      step();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL random_rw i=%0d got %h required %h", i, got_v, exp_v);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear_sweep();
    int busy_cnt, done_at;
    fill_all(4'hF);
    busy_cnt = 0; done_at = -1;
    bus.ClrReq = 1'b1; step(); bus.ClrReq = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.RdAddrA = 4'($urandom_range(0, 15)); bus.RdAddrB = 4'($urandom_range(0, 15));
      step();
      if (bus.Busy === 1'b1) busy_cnt++;
      if (bus.ClrDone === 1'b1) done_at = busy_cnt;
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL sweep_cycle i=%0d got %h required %h", i, got_v, exp_v);
      end
    end
    vectors++;
    if (busy_cnt != 16 || done_at != 16) begin
      miscompares++;
      $display("FAIL sweep_length got busy=%0d done_at=%0d required 16 16", busy_cnt, done_at);
    end
    for (int i = 0; i < 17; i++) begin
      bus.RdAddrA = 4'(i); bus.RdAddrB = 4'(i);
      step();
      vectors++;
      if (i > 0 && (bus.RdDataA !== 4'h0 || bus.RdDataB !== 4'h0)) begin
        miscompares++;
        $display("FAIL sweep_zero addr=%0d got A=%h B=%h required 0", i - 1, bus.RdDataA, bus.RdDataB);
      end
    end
  endtask

  task automatic test_wrerr();
    int err_cnt;
    fill_all(4'h3);
    err_cnt = 0;
    bus.ClrReq = 1'b1; step(); bus.ClrReq = 1'b0;
    for (int i = 0; i < 3; i++) step();
    bus.WrEn = 1'b1; bus.WrAddr = 4'd5; bus.WrData = 4'h9; step();
    idle_inputs();
    vectors++;
    if (bus.WrErr !== 1'b1 || got_v !== exp_v) begin
      miscompares++;
      $display("FAIL wrerr_pulse got err=%b required 1 (all %h vs %h)", bus.WrErr, got_v, exp_v);
    end
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.WrErr === 1'b1) err_cnt++;
    end
    vectors++;
    if (err_cnt != 0) begin
      miscompares++;
      $display("FAIL wrerr_extra got %0d extra pulses required 0", err_cnt);
    end
    bus.RdAddrA = 4'd5; step(); step();
    vectors++;
    if (bus.RdDataA !== 4'h0) begin
      miscompares++;
      $display("FAIL dropped_write got mem5=%h required 0", bus.RdDataA);
    end
  endtask

  task automatic test_reset_mid_sweep();
    fill_all(4'hF);
    bus.ClrReq = 1'b1; step(); bus.ClrReq = 1'b0;
    for (int i = 0; i < 7; i++) step();
    bus.RdAddrA = 4'd12; step();
    vectors++;
    if (bus.RdDataA !== 4'hF) begin
      miscompares++;
      $display("FAIL pre_reset_entry got mem12=%h required f", bus.RdDataA);
    end
    rst_n = 1'b0; step(); rst_n = 1'b1;
    vectors++;
    if (bus.Busy !== 1'b0 || got_v !== 11'h000) begin
      miscompares++;
      $display("FAIL mid_sweep_reset got %h required 000", got_v);
    end
    for (int i = 0; i < 17; i++) begin
      bus.RdAddrA = 4'(i); bus.RdAddrB = 4'(15 - i);
      bus.WrEn = 1'b0;
      step();
      vectors++;
      if (got_v !== 11'h000 || got_v !== exp_v) begin
        miscompares++;
        $display("FAIL post_reset_read i=%0d got %h required 000", i, got_v);
      end
    end
    bus.WrEn = 1'b1; bus.WrAddr = 4'd1; bus.WrData = 4'h6; step();
    idle_inputs(); bus.RdAddrA = 4'd1; step();
    vectors++;
    if (bus.RdDataA !== 4'h6 || bus.WrErr !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_write got A=%h err=%b required 6 0", bus.RdDataA, bus.WrErr);
    end
  endtask

  task automatic test_back_to_back();
    int phase, gap;
    phase = 0; gap = 0;
    bus.ClrReq = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.RdAddrA = 4'($urandom_range(0, 15)); bus.RdAddrB = 4'($urandom_range(0, 15));
      step();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL b2b_cycle i=%0d got %h required %h", i, got_v, exp_v);
      end
      if (phase == 0 && bus.Busy === 1'b1) phase = 1;
      else if (phase == 1 && bus.Busy === 1'b0) begin phase = 2; gap = 1; end
      else if (phase == 2 && bus.Busy === 1'b0) gap++;
      else if (phase == 2 && bus.Busy === 1'b1) phase = 3;
    end
    bus.ClrReq = 1'b0;
    for (int i = 0; i < 20; i++) step();
    vectors++;
    if (phase != 3 || gap != 1) begin
      miscompares++;
      $display("FAIL b2b_gap got phase=%0d gap=%0d required 3 1", phase, gap);
    end
  endtask

  task automatic test_random_all();
    for (int i = 0; i < 400; i++) begin
      bus.WrEn = 1'($urandom_range(0, 1)); bus.WrAddr = 4'($urandom_range(0, 15));
      bus.WrData = 4'($urandom_range(0, 15));
      bus.RdAddrA = 4'($urandom_range(0, 15)); bus.RdAddrB = 4'($urandom_range(0, 15));
      bus.ClrReq = ($urandom_range(0, 24) == 0);
      step();
      vectors++;
      if (got_v !== exp_v) begin
        miscompares++;
        $display("FAIL random_all i=%0d got %h required %h", i, got_v, exp_v);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_random_rw();
    test_clear_sweep();
    test_wrerr();
    test_reset_mid_sweep();
    test_back_to_back();
    test_random_all();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
